// File: rtl/tmds_symbol_decoder.sv
// One-channel TMDS receive decoder: bit-slips the raw deserializer words until DVI
// control tokens line up, then decodes each aligned symbol into pixel byte, control bits and DE.
module tmds_symbol_decoder #(
  parameter int C_lock_tokens = 8,
  parameter int C_dwell       = 1024,
  parameter int C_max_active  = 2047
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int TOK_W   = $clog2(C_lock_tokens + 1);
  localparam int DWELL_W = $clog2(C_dwell + 1);
  localparam int GAP_W   = $clog2(C_max_active + 1);

  localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(C_lock_tokens - 1);
  localparam logic [TOK_W-1:0]   TOK_FULL   = TOK_W'(C_lock_tokens);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(C_dwell - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(C_max_active - 1);
  localparam logic [GAP_W-1:0]   GAP_FULL   = GAP_W'(C_max_active);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         din_prev_q;
  logic [9:0]         word_q, word_d;
  logic [3:0]         offset_q, offset_d;
  logic [TOK_W-1:0]   tok_cnt_q, tok_cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         data_q, data_d;
  logic [1:0]         c_q, c_d;
  logic               de_q, de_d;
  logic               locked_q, locked_d;

  // Offsets only reach 9, so the newest word's MSB never enters a window.
  logic [18:0] cat;
  logic [9:0]  win [10];

  assign cat = {din[8:0], din_prev_q};

  for (genvar gi = 0; gi < 10; gi++) begin : g_win
    assign win[gi] = cat[gi+9:gi];
  end

  always_comb begin
    word_d = win[0];
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) word_d = win[i];
    end
  end

  logic       is_tok;
  logic [1:0] tok_c;

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (word_q)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  logic [7:0] q_un;
  logic [7:0] dec;

  assign q_un   = word_q[9] ? ~word_q[7:0] : word_q[7:0];
  assign dec[0] = q_un[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign dec[gi] = word_q[8] ? (q_un[gi] ^ q_un[gi-1]) : ~(q_un[gi] ^ q_un[gi-1]);
  end

  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o >= 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    tok_cnt_d = tok_cnt_q;
    dwell_d   = dwell_q;
    gap_d     = gap_q;
    case (state_q)
      ST_SEARCH: begin
        // A token beats a simultaneous dwell expiry so the offset is not lost.
        if (is_tok) begin
          tok_cnt_d = TOK_W'(1);
          dwell_d   = '0;
          gap_d     = '0;
          state_d   = (C_lock_tokens <= 1) ? ST_LOCKED : ST_VERIFY;
        end else if (dwell_q >= DWELL_LAST) begin
          offset_d = next_offset(offset_q);
          dwell_d  = '0;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      ST_VERIFY: begin
        if (is_tok) begin
          if (tok_cnt_q >= TOK_LAST) begin
            tok_cnt_d = TOK_FULL;
            gap_d     = '0;
            state_d   = ST_LOCKED;
          end else begin
            tok_cnt_d = tok_cnt_q + TOK_W'(1);
          end
        end else begin
          state_d   = ST_SEARCH;
          offset_d  = next_offset(offset_q);
          tok_cnt_d = '0;
          dwell_d   = '0;
          gap_d     = '0;
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          gap_d = '0;
        end else if (gap_q >= GAP_LAST) begin
          gap_d     = GAP_FULL;
          state_d   = ST_SEARCH;
          offset_d  = next_offset(offset_q);
          tok_cnt_d = '0;
          dwell_d   = '0;
          gap_d     = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d   = ST_SEARCH;
        offset_d  = '0;
        tok_cnt_d = '0;
        dwell_d   = '0;
        gap_d     = '0;
      end
    endcase
  end

  // Outputs are live only while staying locked, so they clear on the edge lock drops.
  always_comb begin
    data_d   = data_q;
    c_d      = c_q;
    de_d     = 1'b0;
    locked_d = (state_d == ST_LOCKED);
    if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
      if (is_tok) begin
        c_d = tok_c;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
      end
    end else begin
      data_d = '0;
      c_d    = '0;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SEARCH;
      din_prev_q <= '0;
      word_q     <= '0;
      offset_q   <= '0;
      tok_cnt_q  <= '0;
      dwell_q    <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      c_q        <= '0;
      de_q       <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_prev_q <= din;
      word_q     <= word_d;
      offset_q   <= offset_d;
      tok_cnt_q  <= tok_cnt_d;
      dwell_q    <= dwell_d;
      gap_q      <= gap_d;
      data_q     <= data_d;
      c_q        <= c_d;
      de_q       <= de_d;
      locked_q   <= locked_d;
    end
  end

  assign data   = data_q;
  assign c      = c_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign offset = offset_q;

endmodule

// File: tb/tb_tmds_symbol_decoder.sv
// Directed bench for tmds_symbol_decoder: lock, decode, abort, loss, slip and reset scenarios.
module tb_tmds_symbol_decoder;

  logic       clk_pixel = 1'b0;
  logic       rst_n;
  logic [9:0] din;
  logic [7:0] data;
  logic [1:0] c;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [9:0] T00 = 10'h354;
  localparam logic [9:0] T01 = 10'h0AB;
  localparam logic [9:0] T10 = 10'h154;
  localparam logic [9:0] T11 = 10'h2AB;

  tmds_symbol_decoder dut (
    .clk_pixel(clk_pixel),
    .rst_n    (rst_n),
    .din      (din),
    .data     (data),
    .c        (c),
    .de       (de),
    .locked   (locked),
    .offset   (offset)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic hold(input logic [9:0] w, input int n);
    din = w;
    step(n);
  endtask

  task automatic check_out(input string tag, input logic exp_de, input logic [7:0] exp_data,
                           input logic [1:0] exp_c);
    check_eq({tag, ".de"}, 32'(de), 32'(exp_de));
    check_eq({tag, ".data"}, 32'(data), 32'(exp_data));
    check_eq({tag, ".c"}, 32'(c), 32'(exp_c));
  endtask

  // Leaves reset released between clock edges with din already set to w.
  task automatic do_reset(input logic [9:0] w);
    din   = w;
    rst_n = 1'b0;
    #2;
    step(2);
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] slip_sym(input int j);
    return ((j % 800) < 160) ? T00 : 10'h0FF;
  endfunction

  logic [9:0] sym, sym_prev;
  int         j;

  initial begin
    // Reset state
    do_reset(T00);
    check_out("reset", 1'b0, 8'h00, 2'b00);
    check_eq("reset.locked", 32'(locked), 32'd0);
    check_eq("reset.offset", 32'(offset), 32'd0);

    // Aligned lock: tokens evaluated on edges 3..10, lock on edge 10
    step(9);
    check_eq("lock.before_8th", 32'(locked), 32'd0);
    step(1);
    check_eq("lock.locked", 32'(locked), 32'd1);
    check_eq("lock.offset", 32'(offset), 32'd0);
    step(1);
    check_out("lock.token_out", 1'b0, 8'h00, 2'b00);
    step(5);
    din = 10'h100;
    step(2);
    check_eq("lock.de_before_data", 32'(de), 32'd0);
    step(1);
    check_out("lock.first_data", 1'b1, 8'h00, 2'b00);
    $display("aligned lock: locked=%0b offset=%0d de=%0b data=0x%02h", locked, offset, de, data);

    // Decode vectors and control tokens while locked
    hold(10'h0FF, 4); check_out("dec.0FF", 1'b1, 8'hFF, 2'b00);
    hold(10'h300, 4); check_out("dec.300", 1'b1, 8'h01, 2'b00);
    hold(10'h2F0, 4); check_out("dec.2F0", 1'b1, 8'hEF, 2'b00);
    hold(T01, 4);     check_out("tok.0AB", 1'b0, 8'hEF, 2'b01);
    hold(T11, 4);     check_out("tok.2AB", 1'b0, 8'hEF, 2'b11);
    hold(T10, 4);     check_out("tok.154", 1'b0, 8'hEF, 2'b10);
    hold(10'h155, 4); check_out("dec.155", 1'b1, 8'hFF, 2'b10);
    check_eq("dec.still_locked", 32'(locked), 32'd1);
    $display("decode: last data=0x%02h c=%0d", data, c);

    // Asynchronous reset between edges while locked
    #3;
    rst_n = 1'b0;
    din   = T10;
    #1;
    check_out("areset", 1'b0, 8'h00, 2'b00);
    check_eq("areset.locked", 32'(locked), 32'd0);
    check_eq("areset.offset", 32'(offset), 32'd0);
    #2;
    rst_n = 1'b1;
    step(9);
    check_eq("relock.before_8th", 32'(locked), 32'd0);
    step(1);
    check_eq("relock.locked", 32'(locked), 32'd1);
    step(1);
    check_out("relock.token_out", 1'b0, 8'h00, 2'b10);
    $display("async reset: relocked=%0b c=%0d", locked, c);

    // Loss of lock after 2047 consecutive data words
    din = 10'h100;
    step(2048);
    check_eq("loss.still_locked", 32'(locked), 32'd1);
    check_out("loss.pre", 1'b1, 8'h00, 2'b10);
    step(1);
    check_eq("loss.locked", 32'(locked), 32'd0);
    check_out("loss.out", 1'b0, 8'h00, 2'b00);
    check_eq("loss.offset", 32'(offset), 32'd1);
    $display("loss of lock: locked=%0b offset=%0d", locked, offset);

    // VERIFY abort after 5 tokens
    do_reset(T11);
    step(5);
    din = 10'h100;
    step(2);
    check_eq("abort.pre_offset", 32'(offset), 32'd0);
    check_eq("abort.pre_locked", 32'(locked), 32'd0);
    step(1);
    check_eq("abort.offset", 32'(offset), 32'd1);
    check_eq("abort.locked", 32'(locked), 32'd0);
    step(500);
    check_eq("abort.offset_held", 32'(offset), 32'd1);
    $display("verify abort: offset=%0d locked=%0b", offset, locked);

    // Token coinciding with dwell expiry keeps the offset
    do_reset(10'h100);
    hold(10'h100, 1021);
    hold(T00, 1);
    hold(10'h100, 1);
    step(1);
    check_eq("tie.offset", 32'(offset), 32'd0);
    step(1);
    check_eq("tie.abort_offset", 32'(offset), 32'd1);
    $display("dwell/token tie: offset=%0d", offset);

    // Dwell stepping and offset wrap
    do_reset(10'h100);
    step(1023);
    check_eq("dwell.offset0", 32'(offset), 32'd0);
    step(1);
    check_eq("dwell.offset1", 32'(offset), 32'd1);
    step(8191);
    check_eq("dwell.offset8", 32'(offset), 32'd8);
    step(1);
    check_eq("dwell.offset9", 32'(offset), 32'd9);
    step(1023);
    check_eq("wrap.hold9", 32'(offset), 32'd9);
    step(1);
    check_eq("wrap.offset0", 32'(offset), 32'd0);
    $display("offset wrap: offset=%0d", offset);

    // Slip search on a stream rotated by 3 bits
    do_reset(10'h0FF);
    sym_prev = 10'h0FF;
    j = 0;
    while (!locked && j < 40000) begin
      sym = slip_sym(j);
      din = {sym[6:0], sym_prev[9:7]};
      step(1);
      sym_prev = sym;
      j++;
    end
    check_eq("slip.locked", 32'(locked), 32'd1);
    check_eq("slip.offset", 32'(offset), 32'd3);
    for (int k = 0; k < 2000 && !de; k++) begin
      sym = slip_sym(j);
      din = {sym[6:0], sym_prev[9:7]};
      step(1);
      sym_prev = sym;
      j++;
    end
    check_eq("slip.de", 32'(de), 32'd1);
    check_eq("slip.data", 32'(data), 32'hFF);
    $display("slip search: cycles=%0d offset=%0d data=0x%02h", j, offset, data);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
